// File: rtl/fpmul_pkg.sv
// Shared types and constants for the FP32 multiplier and its request arbiter.
package fpmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } fpmul_arb_state_t;

  localparam int FLAG_W       = 5;
  localparam int FLAG_TIMEOUT = 4;
  localparam int FLAG_NAN     = 3;
  localparam int FLAG_INF     = 2;
  localparam int FLAG_OVF     = 1;
  localparam int FLAG_UNF     = 0;

  localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;

  // Places each exception bit at its named index so callers never hand-pack the vector.
  function automatic logic [FLAG_W-1:0] mk_flags(input logic tmo, input logic nan,
                                                 input logic inf, input logic ovf,
                                                 input logic unf);
    logic [FLAG_W-1:0] f;
    f               = '0;
    f[FLAG_TIMEOUT] = tmo;
    f[FLAG_NAN]     = nan;
    f[FLAG_INF]     = inf;
    f[FLAG_OVF]     = ovf;
    f[FLAG_UNF]     = unf;
    return f;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] j;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      // One extra bit keeps ptr+k from aliasing before the modulo-N fold.
      sum = {1'b0, ptr_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      j = sum[IW-1:0];
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/fpmul_arbiter.sv
// Time-shares one FP32 multiplier between NUM_REQ requesters: round-robin accept,
// start pulse, done-or-watchdog wait, then a single held response per request.
module fpmul_arbiter
  import fpmul_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 16,
  localparam int IW      = $clog2(NUM_REQ),
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*32-1:0] req_a_i,
  input  logic [NUM_REQ*32-1:0] req_b_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [IW-1:0]         resp_id_o,
  output logic [31:0]           resp_product_o,
  output logic [4:0]            resp_flags_o,
  output logic [31:0]           mul_a_o,
  output logic [31:0]           mul_b_o,
  output logic                  mul_start_o,
  input  logic                  mul_done_i,
  input  logic                  mul_nan_i,
  input  logic                  mul_inf_i,
  input  logic                  mul_ovf_i,
  input  logic                  mul_unf_i,
  input  logic [31:0]           mul_product_i,
  output logic                  busy_o
);

  fpmul_arb_state_t state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [IW-1:0]    id_q, id_d;
  logic [31:0]      prod_q, prod_d;
  logic [4:0]       flags_q, flags_d;

  logic [NUM_REQ-1:0]       gnt;
  logic [IW-1:0]            arb_idx;
  logic                     arb_any;
  logic [NUM_REQ-1:0][31:0] a_lane, b_lane;

  assign a_lane = req_a_i;
  assign b_lane = req_b_i;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    prod_d  = prod_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          a_d     = a_lane[arb_idx];
          b_d     = b_lane[arb_idx];
          id_d    = arb_idx;
          ptr_d   = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
        // done is checked first so it wins a tie with the watchdog threshold
        if (mul_done_i) begin
          prod_d  = mul_product_i;
          flags_d = mk_flags(1'b0, mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i);
          state_d = ST_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          prod_d  = FP32_ZERO;
          flags_d = mk_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      a_q     <= FP32_ZERO;
      b_q     <= FP32_ZERO;
      id_q    <= '0;
      prod_q  <= FP32_ZERO;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      prod_q  <= prod_d;
      flags_q <= flags_d;
    end
  end

  // Grant is gated by rst_n so ready stays low while reset is held, even with requests pending.
  assign req_ready_o    = (rst_n && state_q == ST_IDLE) ? gnt : '0;
  assign mul_start_o    = (state_q == ST_ISSUE);
  assign resp_valid_o   = (state_q == ST_RESP);
  assign busy_o         = (state_q != ST_IDLE);
  assign mul_a_o        = a_q;
  assign mul_b_o        = b_q;
  assign resp_id_o      = id_q;
  assign resp_product_o = prod_q;
  assign resp_flags_o   = flags_q;

endmodule
